button_frontend: RTL and testbench



---
 rtl/button_frontend.sv | 208 ++++++++++++++++++++
 tb/tb_button_frontend.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_frontend.sv
// button_frontend
//
// Debounced, edge-detected front end for the two active-low brightness
// buttons (up/down). Each raw button is synchronized, debounced with a
// stable-level counter and turned into a one-cycle press pulse. Optional
// hold-to-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
// The default build, with the macro undefined, emits exactly one pulse per
// debounced press.
//
// Ports:
//   clk          12 MHz system clock
//   rst_n        synchronous, active-low reset
//   up, down     raw buttons, active-low, asynchronous
//   up_pulse     one-cycle step-up request (registered)
//   down_pulse   one-cycle step-down request (registered)
//   up_held      debounced pressed level of up (registered)
//   down_held    debounced pressed level of down (registered)
//   dbg_state_o  debounce FSM states, {down[1:0], up[1:0]}
//
// Channel index 0 is up and channel index 1 is down.
module button_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       up_held,
  output logic       down_held,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_frontend: DEBOUNCE_CYCLES must be >= 2, repeat counts >= 1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] dcnt_q  [2];
  logic [CNT_W-1:0] dcnt_d  [2];
  logic [1:0]       press_d;
  logic [1:0]       held_d, held_q;
  logic [1:0]       evt;
  logic [1:0]       pulse_d, pulse_q;

  assign raw = {down, up};

  // Two-flop synchronizer; idles at 1 (released) out of reset so a button
  // held through reset is seen as a fresh falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next state. dcnt counts consecutive agreeing samples and is
  // cleared on every state change, so it never exceeds DEB_LAST.
  always_comb begin
    press_d = '0;
    held_d  = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_CHK;
            dcnt_d[i]  = '0;
          end
        end
        PRESS_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i] = PRESSED;
            dcnt_d[i]  = '0;
            press_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_CHK;
            dcnt_d[i]  = '0;
          end
        end
        RELEASE_CHK: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESSED;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          dcnt_d[i]  = '0;
        end
      endcase
      held_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHK);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt_q [2];
  logic [CNT_W-1:0] rcnt_d [2];
  logic [1:0]       first_q, first_d;  // 1 until the first repeat has fired
  logic [1:0]       rep_d;
  logic             both_held;

  // rcnt only advances while PRESSED and holds its value through a rejected
  // release bounce; it reloads on every repeat so it never wraps.
  always_comb begin
    rep_d   = '0;
    first_d = first_q;
    for (int i = 0; i < 2; i++) begin
      rcnt_d[i] = rcnt_q[i];
      if (press_d[i]) begin
        rcnt_d[i]  = '0;
        first_d[i] = 1'b1;
      end else if (state_q[i] == PRESSED && !sync2_q[i]) begin
        if (rcnt_q[i] == (first_q[i] ? RD_LAST : RP_LAST)) begin
          rep_d[i]   = 1'b1;
          rcnt_d[i]  = '0;
          first_d[i] = 1'b0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt_q[0] <= '0;
      rcnt_q[1] <= '0;
      first_q   <= 2'b11;
    end else begin
      rcnt_q[0] <= rcnt_d[0];
      rcnt_q[1] <= rcnt_d[1];
      first_q   <= first_d;
    end
  end

  // Repeats keep counting while both buttons are held but are not emitted.
  assign both_held = held_q[0] & held_q[1];
  assign evt       = press_d | (rep_d & {2{~both_held}});
`else
  assign evt = press_d;
`endif

  // Simultaneous up and down requests cancel each other.
  assign pulse_d = (evt[0] & evt[1]) ? 2'b00 : evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      dcnt_q[0]  <= '0;
      dcnt_q[1]  <= '0;
      held_q     <= '0;
      pulse_q    <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      dcnt_q[0]  <= dcnt_d[0];
      dcnt_q[1]  <= dcnt_d[1];
      held_q     <= held_d;
      pulse_q    <= pulse_d;
    end
  end

  assign up_pulse    = pulse_q[0];
  assign down_pulse  = pulse_q[1];
  assign up_held     = held_q[0];
  assign down_held   = held_q[1];
  assign dbg_state_o = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_button_frontend.sv
// tb_button_frontend
//
// Directed bench for button_frontend with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10
// and REPEAT_PERIOD=3. Expected pulses are queued as {channel, cycle}, where
// channel 0 is up and channel 1 is down. A monitor pops one entry for every
// pulse the DUT shows. Held levels are compared directly by the driver.
// Define BTN_AUTOREPEAT_EN to match a DUT built with auto-repeat.
module tb_button_frontend;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  // Inputs change at a negedge with cycle count c. The pulse shows at the
  // negedge with count c+LAT: 1 edge into sync1, 2 edges to enter PRESS_CHK,
  // then DEB more edges.
  localparam int LAT = DEB + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, down;
  logic       up_pulse, down_pulse, up_held, down_held;
  logic [3:0] dbg_state;

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_act, mon_exp;

  button_frontend #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up),
    .down       (down),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .up_held    (up_held),
    .down_held  (down_held),
    .dbg_state_o(dbg_state)
  );

  // Clock and cycle count. Inputs change and outputs are sampled on negedges.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic ch, input int at);
    exp_q.push_back({ch, 31'(at)});
  endtask

  // Monitor: every visible pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (up_pulse || down_pulse) begin
      mon_act = {down_pulse, cyc[30:0]};
      checks++;
      if (up_pulse && down_pulse) begin
        errors++;
        $display("FAIL pulse_both: up and down pulse together at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: ch %0d pulse at cycle %0d, none expected",
                 down_pulse, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp)
        begin
          errors++;
          $display("FAIL pulse_match: got ch %0d cycle %0d expected ch %0d cycle %0d",
                   mon_act[31], mon_act[30:0], mon_exp[31], mon_exp[30:0]);
        end
      end
    end
  end

  int c;
  int r;
  int rep_off[9] = '{17, 20, 23, 26, 29, 32, 35, 38, 41};

  initial begin
    rst_n = 1'b0;
    up    = 1'b1;
    down  = 1'b1;
    tick(3);
    chk("rst_up_pulse",   up_pulse,   1'b0);
    chk("rst_down_pulse", down_pulse, 1'b0);
    chk("rst_up_held",    up_held,    1'b0);
    chk("rst_down_held",  down_held,  1'b0);
    rst_n = 1'b1;
    tick(3);

    // 1: basic press latency and held level, then a clean release.
    c  = cyc;
    up = 1'b0;
    expect_pulse(1'b0, c + LAT);
    tick(LAT - 1);
    chk("t1_held_before", up_held, 1'b0);
    tick(1);
    chk("t1_held_rise", up_held, 1'b1);
    chk("t1_down_held", down_held, 1'b0);
    tick(1);
    chk("t1_pulse_width", up_pulse, 1'b0);
    up = 1'b1;
    r  = cyc;
    tick(6);
    chk("t1_held_release_chk", up_held, 1'b1);
    tick(2);
    chk("t1_held_fall", up_held, 1'b0);
    tick(4);

    // 2: press bounce 3 low / 1 high / 2 low is rejected.
    up = 1'b0;
    tick(3);
    up = 1'b1;
    tick(1);
    up = 1'b0;
    tick(2);
    up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t2_bounce_held", up_held, 1'b0);
    end
    tick(2);

    // 3: long hold, with repeats when auto-repeat is built.
    c  = cyc;
    up = 1'b0;
    expect_pulse(1'b0, c + LAT);
`ifdef BTN_AUTOREPEAT_EN
    foreach (rep_off[k]) expect_pulse(1'b0, c + rep_off[k]);
`endif
    tick(20);
    chk("t3_held_mid", up_held, 1'b1);
    tick(20);
    up = 1'b1;
    tick(12);
    chk("t3_held_after", up_held, 1'b0);

    // 4: release bounce of two high samples keeps the button held.
    c  = cyc;
    up = 1'b0;
    expect_pulse(1'b0, c + LAT);
    tick(LAT);
    up = 1'b1;
    tick(2);
    up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t4_held_bounce", up_held, 1'b1);
    end
    up = 1'b1;
    tick(12);
    chk("t4_held_after", up_held, 1'b0);

    // 5: simultaneous press cancels both pulses, and repeats stay quiet.
    up   = 1'b0;
    down = 1'b0;
    tick(LAT);
    chk("t5_up_held",   up_held,   1'b1);
    chk("t5_down_held", down_held, 1'b1);
    tick(20);
    chk("t5_up_held_late",   up_held,   1'b1);
    chk("t5_down_held_late", down_held, 1'b1);
    up   = 1'b1;
    down = 1'b1;
    tick(12);
    chk("t5_up_released",   up_held,   1'b0);
    chk("t5_down_released", down_held, 1'b0);

    // 6: down held through reset, reset again mid PRESS_CHK, then a clean press.
    rst_n = 1'b0;
    down  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_down_held",  down_held,  1'b0);
    chk("t6_rst_down_pulse", down_pulse, 1'b0);
    chk("t6_rst_up_held",    up_held,    1'b0);
    tick(1);
    rst_n = 1'b1;
    c = cyc;
    expect_pulse(1'b1, c + LAT);
    tick(LAT);
    chk("t6_down_held", down_held, 1'b1);
    tick(3);
    down = 1'b1;
    tick(12);
    chk("t6_down_released", down_held, 1'b0);

    tick(5);
    while (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL pulse_missing: got no pulse, expected ch %0d at cycle %0d",
               mon_exp[31], mon_exp[30:0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
